a2d_intf: RTL and testbench

SPI master front-end for the 8-channel, 12-bit line-sensor A2D (ADC128S-style). Consumes strt_cnv and chnnl from the motion controller. Runs two 16-bit SPI transactions: the first addresses the channel, the second reads the conversion. Returns A2D_res with a cnv_cmplt strobe; sits directly upstream of the motion controller's A2D_1/A2D_2 wait states.

---
 rtl/a2d_pkg.sv | 25 ++
 rtl/a2d_intf_spi.sv | 69 ++++++
 rtl/a2d_intf.sv | 101 ++++++++++
 tb/tb_a2d_intf.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/a2d_pkg.sv
// Shared constants for the A2D SPI front-end: state encoding, SCLK divider
// load/end points, transfer length and the channel-select command format.
package a2d_pkg;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] TX1  = 3'd1;
  localparam logic [2:0] GAP  = 3'd2;
  localparam logic [2:0] TX2  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  // Divider preload puts the first SCLK fall 9 clocks into the SS_n window.
  localparam logic [4:0] DIV_START = 5'b10111;
  // Divider value at which SS_n is released after the last rise.
  localparam logic [4:0] DIV_END   = 5'b11110;

  localparam int BITS_PER_XFER = 16;

  localparam logic [10:0] CMD_PAD = 11'h000;

  // The ADC takes the channel address in bits [13:11] of the command word.
  function automatic logic [15:0] a2d_cmd(input logic [2:0] ch);
    return {2'b00, ch, CMD_PAD};
  endfunction

endpackage

// File: rtl/a2d_intf_spi.sv
// spi_mstr16: generic 16-bit SPI master transaction engine (mode 3, SCLK
// idles high). A wrt while idle loads cmd and opens an SS_n window; done is
// asserted combinationally on the clock that closes the window.
module spi_mstr16
  import a2d_pkg::*;
#(
  parameter int SCLK_DIV_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt,
  input  logic [15:0] cmd,
  input  logic        MISO,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI
);

  localparam int DIV_SPAN = 2 ** SCLK_DIV_W;
  localparam logic [SCLK_DIV_W-1:0] DIV_LD   = SCLK_DIV_W'(DIV_SPAN - 32 + int'(DIV_START));
  localparam logic [SCLK_DIV_W-1:0] DIV_IDLE = SCLK_DIV_W'(DIV_SPAN - 32 + int'(DIV_END));
  localparam logic [SCLK_DIV_W-1:0] DIV_LAST = SCLK_DIV_W'(DIV_SPAN - 32 + int'(DIV_END) - 1);
  localparam logic [SCLK_DIV_W-1:0] DIV_MID  = SCLK_DIV_W'(DIV_SPAN / 2 - 1);
  localparam logic [4:0]            XFER_BITS = 5'(BITS_PER_XFER);

  logic [SCLK_DIV_W-1:0] div;
  logic [15:0]           tx_shft;
  logic [15:0]           rx_shft;
  logic [4:0]            bit_cnt;
  logic                  rise;

  // SCLK is the divider MSB; parking div at DIV_IDLE keeps it high between windows.
  assign SCLK    = div[SCLK_DIV_W-1];
  assign MOSI    = ~SS_n & tx_shft[15];
  assign rise    = ~SS_n && (div == DIV_MID);
  assign done    = ~SS_n && (bit_cnt == XFER_BITS) && (div == DIV_LAST);
  assign rd_data = rx_shft;

  // Divider, shift registers, bit counter and slave select.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      SS_n    <= 1'b1;
      div     <= DIV_IDLE;
      tx_shft <= 16'h0000;
      rx_shft <= 16'h0000;
      bit_cnt <= 5'd0;
    end else if (SS_n) begin
      if (wrt) begin
        SS_n    <= 1'b0;
        div     <= DIV_LD;
        tx_shft <= cmd;
        bit_cnt <= 5'd0;
      end
    end else begin
      div <= div + 1'b1;
      if (rise) begin
        rx_shft <= {rx_shft[14:0], MISO};
        tx_shft <= {tx_shft[14:0], 1'b0};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (done) begin
        SS_n <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/a2d_intf.sv
// a2d_intf: SPI front-end for the 8-channel 12-bit line-sensor A2D.
// A request runs two back-to-back transactions (address, then read) and
// returns the 12-bit result with cnv_cmplt.
// Build option A2D_STICKY_CMPLT_EN: cnv_cmplt holds high until the next
// accepted strt_cnv instead of pulsing for one clock.
//
// state | meaning
// IDLE  | waiting for strt_cnv
// TX1   | first transaction: send channel address
// GAP   | one clock with SS_n high between transactions
// TX2   | second transaction: same command, conversion shifts in
// DONE  | result registered, cnv_cmplt asserted
module a2d_intf
  import a2d_pkg::*;
#(
  parameter int SCLK_DIV_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        strt_cnv,
  input  logic [2:0]  chnnl,
  output logic        cnv_cmplt,
  output logic [11:0] A2D_res,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  logic [2:0]  state;
  logic [2:0]  nxt_state;
  logic [2:0]  ch_lat;
  logic        accept;
  logic        wrt;
  logic        done;
  logic [15:0] cmd;
  logic [15:0] rd_data;
  logic [3:0]  rx_unused;

  assign accept    = (state == IDLE) && strt_cnv;
  assign wrt       = accept || (state == GAP);
  // In IDLE the channel is taken straight from the input on the accepting edge.
  assign cmd       = (state == IDLE) ? a2d_cmd(chnnl) : a2d_cmd(ch_lat);
  assign rx_unused = rd_data[15:12];

  spi_mstr16 #(
    .SCLK_DIV_W(SCLK_DIV_W)
  ) u_spi (
    .clk     (clk),
    .rst_n   (rst_n),
    .wrt     (wrt),
    .cmd     (cmd),
    .MISO    (MISO),
    .done    (done),
    .rd_data (rd_data),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI)
  );

  // Next-state decode for the two-transaction sequence.
  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:    if (strt_cnv) nxt_state = TX1;
      TX1:     if (done) nxt_state = GAP;
      GAP:     nxt_state = TX2;
      TX2:     if (done) nxt_state = DONE;
      DONE:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // State, channel latch, result register and completion flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ch_lat    <= 3'd0;
      A2D_res   <= 12'h000;
      cnv_cmplt <= 1'b0;
    end else begin
      state <= nxt_state;
      if (accept) begin
        ch_lat <= chnnl;
      end
      if ((state == TX2) && done) begin
        A2D_res <= rd_data[11:0];
      end
`ifdef A2D_STICKY_CMPLT_EN
      if ((state == TX2) && done) begin
        cnv_cmplt <= 1'b1;
      end else if (accept) begin
        cnv_cmplt <= 1'b0;
      end
`else
      cnv_cmplt <= (state == TX2) && done;
`endif
    end
  end

endmodule

// File: tb/tb_a2d_intf.sv
// Directed testbench for a2d_intf: an SPI slave model drives MISO on SCLK
// falls and captures MOSI; each conversion's windows are checked for length,
// edge counts, command word and the inter-window gap.
module tb_a2d_intf;

  typedef struct {
    int          low;
    int          falls;
    int          rises;
    int          gap;
    logic [15:0] mosi;
  } win_t;

  logic        clk;
  logic        rst_n;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] A2D_res;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;

  int n_chk;
  int n_fail;
  int cyc;
  int cmplt_rises;
  int sclk_viol;
  int high_run;

  logic [15:0] miso_q[$];
  win_t        win_q[$];
  win_t        cur;
  logic [15:0] miso_word;
  logic        prev_ss;
  logic        prev_sclk;
  logic        prev_cmplt;

  a2d_intf dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .strt_cnv  (strt_cnv),
    .chnnl     (chnnl),
    .cnv_cmplt (cnv_cmplt),
    .A2D_res   (A2D_res),
    .SS_n      (SS_n),
    .SCLK      (SCLK),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // SPI slave model and bus monitor.
  initial begin
    prev_ss     = 1'b1;
    prev_sclk   = 1'b1;
    prev_cmplt  = 1'b0;
    cmplt_rises = 0;
    sclk_viol   = 0;
    high_run    = 0;
    miso_word   = 16'h0000;
    cur         = '{0, 0, 0, 0, 16'h0000};
  end

  always @(negedge clk) begin
    if (SS_n === 1'b0 && prev_ss === 1'b1) begin
      cur.low   = 0;
      cur.falls = 0;
      cur.rises = 0;
      cur.mosi  = 16'h0000;
      cur.gap   = high_run;
      high_run  = 0;
      if (miso_q.size() > 0) miso_word = miso_q.pop_front();
      else miso_word = 16'h0000;
    end
    if (SS_n === 1'b0) begin
      cur.low = cur.low + 1;
      if (SCLK === 1'b0 && prev_sclk === 1'b1) begin
        cur.mosi = {cur.mosi[14:0], MOSI};
        if (cur.falls < 16) MISO = miso_word[15 - cur.falls];
        cur.falls = cur.falls + 1;
      end
      if (SCLK === 1'b1 && prev_sclk === 1'b0) cur.rises = cur.rises + 1;
    end else if (SS_n === 1'b1) begin
      if (prev_ss === 1'b0) win_q.push_back(cur);
      high_run = high_run + 1;
      if (SCLK !== 1'b1) sclk_viol = sclk_viol + 1;
    end
    if (cnv_cmplt === 1'b1 && prev_cmplt !== 1'b1) cmplt_rises = cmplt_rises + 1;
    prev_ss    = SS_n;
    prev_sclk  = SCLK;
    prev_cmplt = cnv_cmplt;
  end

  task automatic pulse_strt(input logic [2:0] ch);
    @(negedge clk);
    chnnl    = ch;
    strt_cnv = 1'b1;
    @(negedge clk);
    strt_cnv = 1'b0;
  endtask

  task automatic run_conv(input logic [2:0] ch, input logic [15:0] rx_word, input bit interfere);
    int          t0;
    int          base;
    bit          seen;
    win_t        w;
    logic [15:0] exp_cmd;
    exp_cmd = {2'b00, ch, 11'h000};
    miso_q.push_back(16'hC3C3 ^ {13'h0000, ch});
    miso_q.push_back(rx_word);
    base = cmplt_rises;
    @(negedge clk);
    chnnl    = ch;
    strt_cnv = 1'b1;
    t0       = cyc;
    @(negedge clk);
    strt_cnv = 1'b0;
    chnnl    = ~ch;
    check("cmplt_clr_on_accept", cnv_cmplt, 0);
    check("ss_low_after_accept", SS_n, 0);
    if (interfere) begin
      repeat (99) @(negedge clk);
      pulse_strt(3'd6);
      chnnl = ~ch;
      repeat (718) @(negedge clk);
      pulse_strt(3'd6);
      chnnl = ~ch;
    end
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (cnv_cmplt === 1'b1) seen = 1'b1;
    end
    check("cmplt_seen", seen, 1);
    if (seen) begin
      check("latency", cyc - t0, 1040);
      check("a2d_res", A2D_res, {20'h00000, rx_word[11:0]});
      @(negedge clk);
`ifdef A2D_STICKY_CMPLT_EN
      check("cmplt_held", cnv_cmplt, 1);
`else
      check("cmplt_pulse_width", cnv_cmplt, 0);
`endif
      check("cmplt_count", cmplt_rises - base, 1);
      check("win_count", win_q.size(), 2);
      for (int k = 0; k < 2 && win_q.size() > 0; k++) begin
        w = win_q.pop_front();
        check("ss_low_len", w.low, 519);
        check("sclk_falls", w.falls, 16);
        check("sclk_rises", w.rises, 16);
        check("mosi_cmd", w.mosi, exp_cmd);
        if (k == 1) check("gap_len", w.gap, 1);
      end
    end
    win_q.delete();
  endtask

  task automatic reset_abort;
    int base;
    miso_q.push_back(16'h1111);
    miso_q.push_back(16'h0DEF);
    base = cmplt_rises;
    pulse_strt(3'd2);
    repeat (720) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_ss_n", SS_n, 1);
    check("rst_sclk", SCLK, 1);
    check("rst_mosi", MOSI, 0);
    check("rst_a2d_res", A2D_res, 0);
    check("rst_cmplt", cnv_cmplt, 0);
    repeat (1100) @(negedge clk);
    check("rst_no_cmplt", cmplt_rises - base, 0);
    check("rst_ss_idle", SS_n, 1);
    win_q.delete();
    miso_q.delete();
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    strt_cnv = 1'b0;
    chnnl    = 3'd0;
    MISO     = 1'b0;
    repeat (3) @(negedge clk);
    check("init_ss_n", SS_n, 1);
    check("init_sclk", SCLK, 1);
    check("init_mosi", MOSI, 0);
    check("init_cmplt", cnv_cmplt, 0);
    check("init_a2d_res", A2D_res, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_conv(3'd3, 16'h0ABC, 1'b0);
    run_conv(3'd5, 16'h1234, 1'b1);
    reset_abort();
    run_conv(3'd7, 16'hFFFF, 1'b0);

    run_conv(3'd1, 16'h0001, 1'b0);
    run_conv(3'd0, 16'hF800, 1'b0);
    run_conv(3'd4, 16'h0555, 1'b0);
    run_conv(3'd2, 16'h7AAA, 1'b0);
    run_conv(3'd3, 16'h0123, 1'b0);
    run_conv(3'd7, 16'h8F0F, 1'b0);

    repeat (5) @(negedge clk);
    check("sclk_idle_high", sclk_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
